// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO, programmable divisor, 5-8 data bits, optional parity and 1/2 stop bits.
// Optional line-break support is compiled in with the UART_TX_BREAK_EN macro (adds the brk input).
module uart_tx_fifo #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             load,
    input  logic [7:0]       out_port,
    input  logic [1:0]       data_len,
    input  logic             parity_en,
    input  logic             odd_n_even,
    input  logic             two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic             brk,
`endif
    output logic             txrdy,
    output logic             tx,
    output logic             busy,
    output logic [AW:0]      fifo_level,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_BREAK  = 3'd6,
        S_GAP    = 3'd7
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             brk_req;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] timer;
    logic             bit_tick;
    logic [7:0]       shreg;
    logic [1:0]       len_q;
    logic             par_en_q;
    logic             par_bit;
    logic             two_stop_q;
    logic [2:0]       bit_cnt;
    logic [2:0]       last_bit;

`ifdef UART_TX_BREAK_EN
    assign brk_req = brk;
`else
    assign brk_req = 1'b0;
`endif

    function automatic logic [7:0] len_mask(input logic [1:0] len);
        case (len)
            2'b00:   len_mask = 8'h1F;
            2'b01:   len_mask = 8'h3F;
            2'b10:   len_mask = 8'h7F;
            default: len_mask = 8'hFF;
        endcase
    endfunction

    // full/empty come from registered occupancy, so a pop in the same cycle never rescues a load into a full FIFO
    assign full     = (fifo_level == FULL_LEVEL);
    assign empty    = (fifo_level == '0);
    assign push     = load && !full;
    assign pop      = (state == S_IDLE) && !empty && !brk_req;
    assign busy     = (state != S_IDLE) || !empty;
    assign bit_tick = (timer == div_q);
    assign last_bit = {1'b0, len_q} + 3'd4;

    always_comb begin
        level_next = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + (AW+1)'(1);
            2'b01:   level_next = fifo_level - (AW+1)'(1);
            default: level_next = fifo_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            txrdy      <= 1'b1;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_next;
            txrdy      <= (level_next != FULL_LEVEL);
            ovf        <= load && full;
        end
    end

    // Frame sequencer; tx is registered here so reset forces it high on the next edge without a glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            timer      <= '0;
            bit_cnt    <= '0;
            div_q      <= '0;
            shreg      <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit    <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            if (state == S_IDLE || state == S_BREAK || bit_tick) begin
                timer <= '0;
            end else begin
                timer <= timer + DIV_W'(1);
            end

            case (state)
                S_IDLE: begin
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                    if (brk_req) begin
                        state <= S_BREAK;
                        tx    <= 1'b0;
                    end else if (pop) begin
                        state      <= S_START;
                        tx         <= 1'b0;
                        shreg      <= mem[rd_ptr];
                        div_q      <= baud_div;
                        len_q      <= data_len;
                        par_en_q   <= parity_en;
                        two_stop_q <= two_stop;
                        par_bit    <= (^(mem[rd_ptr] & len_mask(data_len))) ^ odd_n_even;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        state   <= S_DATA;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == last_bit) begin
                            if (par_en_q) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP1;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        state <= S_STOP1;
                        tx    <= 1'b1;
                    end
                end
                S_STOP1: begin
                    tx <= 1'b1;
                    if (bit_tick) begin
                        state <= two_stop_q ? S_STOP2 : S_IDLE;
                    end
                end
                S_STOP2: begin
                    tx <= 1'b1;
                    if (bit_tick) begin
                        state <= S_IDLE;
                    end
                end
                S_BREAK: begin
                    tx <= 1'b0;
                    if (!brk_req) begin
                        // Guarantee a full idle-high bit period after the break ends
                        state <= S_GAP;
                        tx    <= 1'b1;
                        div_q <= baud_div;
                    end
                end
                S_GAP: begin
                    tx <= 1'b1;
                    if (bit_tick) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: framing, parity, FIFO overflow, config latch, reset and optional break.
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        load = 1'b0;
  logic [7:0]  out_port = 8'h00;
  logic [1:0]  data_len = 2'b11;
  logic        parity_en = 1'b0;
  logic        odd_n_even = 1'b0;
  logic        two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic        brk = 1'b0;
`endif
  logic        txrdy;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_d;

  uart_tx_fifo #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .load(load), .out_port(out_port),
    .data_len(data_len), .parity_en(parity_en), .odd_n_even(odd_n_even), .two_stop(two_stop),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .txrdy(txrdy), .tx(tx), .busy(busy), .fifo_level(fifo_level), .ovf(ovf)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] b);
    out_port = b;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic frame_check(input string tag, input logic [15:0] bits, input int n, input int per);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < per; c++) begin
        check(tag, {31'b0, tx}, {31'b0, bits[i]});
        step(1);
      end
    end
  endtask

  task automatic rx_frame(output logic [7:0] d, input int nbits, input int per);
    int t;
    t = 0;
    d = 8'h00;
    while (tx !== 1'b0 && t < 5000) begin
      step(1);
      t++;
    end
    check("rx_start_timeout", {31'b0, (t < 5000)}, 32'd1);
    step(per / 2);
    check("rx_start_bit", {31'b0, tx}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      step(per);
      d[i] = tx;
    end
    step(per);
    check("rx_stop_bit", {31'b0, tx}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 5000) begin
      step(1);
      t++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int t;
    logic low_seen;

    // reset values
    step(2);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_txrdy", {31'b0, txrdy}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_level", {28'b0, fifo_level}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    reset = 1'b0;
    step(1);

    // single byte 0x55, 8N1, 4 clocks per bit
    baud_div = 16'd3; data_len = 2'b11; parity_en = 1'b0; two_stop = 1'b0;
    do_load(8'h55);
    check("t1_level", {28'b0, fifo_level}, 32'd1);
    check("t1_tx_idle", {31'b0, tx}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    step(1);
    frame_check("t1_bits", 16'b0000_0010_1010_1010, 10, 4);
    check("t1_busy_end", {31'b0, busy}, 32'd0);
    check("t1_tx_end", {31'b0, tx}, 32'd1);

    // 6 data bits, odd parity, two stops: 0x3B -> 0,1,1,0,1,1,1,0,1,1
    baud_div = 16'd1; data_len = 2'b01; parity_en = 1'b1; odd_n_even = 1'b1; two_stop = 1'b1;
    do_load(8'h3B);
    step(1);
    frame_check("t2_bits", 16'b0000_0011_0111_0110, 10, 2);
    check("t2_busy_end", {31'b0, busy}, 32'd0);

    // baud_div=0, 5 bits, even parity: 0x13 -> 0,1,1,0,0,1,(p=1),1
    baud_div = 16'd0; data_len = 2'b00; parity_en = 1'b1; odd_n_even = 1'b0; two_stop = 1'b0;
    do_load(8'h13);
    step(1);
    frame_check("t3_bits", 16'b0000_0000_1110_0110, 8, 1);
    check("t3_busy_end", {31'b0, busy}, 32'd0);

    // FIFO fill and overflow: 10 back-to-back loads, 9 accepted
    baud_div = 16'd100; data_len = 2'b11; parity_en = 1'b0; two_stop = 1'b0;
    load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out_port = 8'h30 + 8'(i);
      if (i < 9) exp_q.push_back(8'h30 + 8'(i));
      step(1);
      if (i == 7) begin
        check("t4_level7", {28'b0, fifo_level}, 32'd7);
        check("t4_txrdy7", {31'b0, txrdy}, 32'd1);
      end
      if (i == 8) begin
        check("t4_level8", {28'b0, fifo_level}, 32'd8);
        check("t4_txrdy8", {31'b0, txrdy}, 32'd0);
        check("t4_no_ovf", {31'b0, ovf}, 32'd0);
      end
      if (i == 9) begin
        check("t4_ovf", {31'b0, ovf}, 32'd1);
        check("t4_level_ovf", {28'b0, fifo_level}, 32'd8);
      end
    end
    load = 1'b0;
    step(1);
    check("t4_ovf_pulse", {31'b0, ovf}, 32'd0);
    for (int f = 0; f < 9; f++) begin
      rx_frame(rx_d, 8, 101);
      check("t4_byte", {24'b0, rx_d}, {24'b0, exp_q.pop_front()});
    end
    wait_idle("t4_idle");
    check("t4_level_end", {28'b0, fifo_level}, 32'd0);
    check("t4_txrdy_end", {31'b0, txrdy}, 32'd1);

    // config latch: data_len changes to 5 bits during the first frame
    baud_div = 16'd1; data_len = 2'b11;
    do_load(8'hC5);
    do_load(8'hDA);
    check("t5_start", {31'b0, tx}, 32'd0);
    data_len = 2'b00;
    rx_frame(rx_d, 8, 2);
    check("t5_byte8", {24'b0, rx_d}, 32'hC5);
    rx_frame(rx_d, 5, 2);
    check("t5_byte5", {24'b0, rx_d}, 32'h1A);
    wait_idle("t5_idle");

    // reset during DATA
    baud_div = 16'd3; data_len = 2'b11;
    do_load(8'h00);
    do_load(8'h00);
    step(6);
    check("t6_in_data", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    step(1);
    check("t6_tx", {31'b0, tx}, 32'd1);
    check("t6_level", {28'b0, fifo_level}, 32'd0);
    check("t6_txrdy", {31'b0, txrdy}, 32'd1);
    check("t6_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx !== 1'b1) low_seen = 1'b1;
      step(1);
    end
    check("t6_quiet", {31'b0, low_seen}, 32'd0);

`ifdef UART_TX_BREAK_EN
    // break raised mid-frame: frame completes, then line held low
    baud_div = 16'd3; data_len = 2'b11;
    do_load(8'hFF);
    step(1);
    brk = 1'b1;
    frame_check("t7_frame", 16'b0000_0011_1111_1110, 10, 4);
    check("t7_idle_cycle", {31'b0, tx}, 32'd1);
    step(1);
    do_load(8'h00);
    for (int i = 0; i < 8; i++) begin
      check("t7_break_low", {31'b0, tx}, 32'd0);
      step(1);
    end
    check("t7_busy", {31'b0, busy}, 32'd1);
    check("t7_no_pop", {28'b0, fifo_level}, 32'd1);
    brk = 1'b0;
    t = 0;
    step(1);
    while (tx === 1'b1 && t < 100) begin
      t++;
      step(1);
    end
    check("t7_gap_min", {31'b0, (t >= 4)}, 32'd1);
    check("t7_gap_bound", {31'b0, (t < 100)}, 32'd1);
    wait_idle("t7_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
